// File: rtl/key_debouncer.sv
// Pushbutton conditioning: 2-flop sync, per-key debounce FSM, press/release pulses and key-0 press counter.
// Optional auto-repeat of KEY_PRESS while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debouncer #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] KEY_DOWN,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [7:0]          PRESS_COUNT
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int RPT_MAX_C = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_MAX_C = (DEBOUNCE_CYCLES > RPT_MAX_C) ? DEBOUNCE_CYCLES : RPT_MAX_C;
    localparam int CW        = $clog2(CNT_MAX_C + 1);

    localparam logic [CW-1:0] DB_LAST_C  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] pressed_s;
    state_t              state_r [NUM_KEYS];
    state_t              state_s [NUM_KEYS];
    logic [CW-1:0]       cnt_r   [NUM_KEYS];
    logic [CW-1:0]       cnt_s   [NUM_KEYS];
    logic [NUM_KEYS-1:0] down_s;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] release_s;
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] RPT_DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_PERIOD_C = CW'(REPEAT_PERIOD);
    logic [CW-1:0]       rpt_cnt_r [NUM_KEYS];
    logic [CW-1:0]       rpt_cnt_s [NUM_KEYS];
    logic [NUM_KEYS-1:0] rpt_phase_r;
    logic [NUM_KEYS-1:0] rpt_phase_s;
`endif

    assign pressed_s = ~sync2_r;

    // Two-flop synchroniser for the asynchronous, active-low keys
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_r <= {NUM_KEYS{1'b1}};
            sync2_r <= {NUM_KEYS{1'b1}};
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
        end
    end

    // Per-key debounce next-state, pulse and level decode
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_s[i]   = state_r[i];
            cnt_s[i]     = cnt_r[i];
            down_s[i]    = KEY_DOWN[i];
            press_s[i]   = 1'b0;
            release_s[i] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_s[i]   = rpt_cnt_r[i];
            rpt_phase_s[i] = rpt_phase_r[i];
`endif
            case (state_r[i])
                IDLE: begin
                    if (pressed_s[i]) begin
                        state_s[i] = PRESS_WAIT;
                        cnt_s[i]   = CNT_ONE_C;
                    end else begin
                        cnt_s[i]   = CNT_ZERO_C;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s[i]) begin
                        state_s[i] = IDLE;
                        cnt_s[i]   = CNT_ZERO_C;
                    end else if (cnt_r[i] == DB_LAST_C) begin
                        state_s[i] = PRESSED;
                        cnt_s[i]   = CNT_ZERO_C;
                        press_s[i] = 1'b1;
                        down_s[i]  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_s[i]   = CNT_ZERO_C;
                        rpt_phase_s[i] = 1'b0;
`endif
                    end else begin
                        cnt_s[i]   = cnt_r[i] + CNT_ONE_C;
                    end
                end
                PRESSED: begin
                    if (!pressed_s[i]) begin
                        state_s[i] = RELEASE_WAIT;
                        cnt_s[i]   = CNT_ONE_C;
                    end else begin
                        state_s[i] = PRESSED;
`ifdef KEY_AUTOREPEAT_EN
                        // First repeat after the delay, then one per period
                        if (!rpt_phase_r[i] && ((rpt_cnt_r[i] + CNT_ONE_C) == RPT_DELAY_C)) begin
                            press_s[i]     = 1'b1;
                            rpt_cnt_s[i]   = CNT_ZERO_C;
                            rpt_phase_s[i] = 1'b1;
                        end else if (rpt_phase_r[i] && ((rpt_cnt_r[i] + CNT_ONE_C) == RPT_PERIOD_C)) begin
                            press_s[i]     = 1'b1;
                            rpt_cnt_s[i]   = CNT_ZERO_C;
                        end else begin
                            rpt_cnt_s[i]   = rpt_cnt_r[i] + CNT_ONE_C;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s[i]) begin
                        state_s[i]   = PRESSED;
                        cnt_s[i]     = CNT_ZERO_C;
                    end else if (cnt_r[i] == DB_LAST_C) begin
                        state_s[i]   = IDLE;
                        cnt_s[i]     = CNT_ZERO_C;
                        release_s[i] = 1'b1;
                        down_s[i]    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_s[i]   = CNT_ZERO_C;
                        rpt_phase_s[i] = 1'b0;
`endif
                    end else begin
                        cnt_s[i]     = cnt_r[i] + CNT_ONE_C;
                    end
                end
                default: begin
                    state_s[i] = IDLE;
                    cnt_s[i]   = CNT_ZERO_C;
                    down_s[i]  = 1'b0;
                end
            endcase
        end
    end

    // Debounce state, counters and registered key outputs
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= CNT_ZERO_C;
`ifdef KEY_AUTOREPEAT_EN
                rpt_cnt_r[i] <= CNT_ZERO_C;
`endif
            end
`ifdef KEY_AUTOREPEAT_EN
            rpt_phase_r <= {NUM_KEYS{1'b0}};
`endif
            KEY_DOWN    <= {NUM_KEYS{1'b0}};
            KEY_PRESS   <= {NUM_KEYS{1'b0}};
            KEY_RELEASE <= {NUM_KEYS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
`ifdef KEY_AUTOREPEAT_EN
                rpt_cnt_r[i] <= rpt_cnt_s[i];
`endif
            end
`ifdef KEY_AUTOREPEAT_EN
            rpt_phase_r <= rpt_phase_s;
`endif
            KEY_DOWN    <= down_s;
            KEY_PRESS   <= press_s;
            KEY_RELEASE <= release_s;
        end
    end

    // Key-0 press counter, wraps naturally at 8 bits
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            PRESS_COUNT <= 8'd0;
        end else if (press_s[0]) begin
            PRESS_COUNT <= PRESS_COUNT + 8'd1;
        end else begin
            PRESS_COUNT <= PRESS_COUNT;
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised and directed bench for key_debouncer against a run-length reference model.
module tb_key_debouncer;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          CLOCK_50 = 1'b0;
    logic          RESET    = 1'b0;
    logic [NK-1:0] KEY      = 4'hF;
    logic [NK-1:0] KEY_DOWN;
    logic [NK-1:0] KEY_PRESS;
    logic [NK-1:0] KEY_RELEASE;
    logic [7:0]    PRESS_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: delayed key samples, run length of the synced value, accepted level
    logic [NK-1:0] m_d1, m_d2, m_down, m_press, m_rel, m_prev;
    logic [7:0]    m_count;
    int            m_run [NK];
    int            m_rep [NK];

    key_debouncer #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY), .KEY_DOWN(KEY_DOWN),
        .KEY_PRESS(KEY_PRESS), .KEY_RELEASE(KEY_RELEASE), .PRESS_COUNT(PRESS_COUNT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_d1 = 4'hF; m_d2 = 4'hF; m_down = 4'h0; m_press = 4'h0; m_rel = 4'h0;
        m_prev = 4'h0; m_count = 8'd0;
        for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_rep[i] = 0; end
    endtask

    // A change is accepted once DB+1 consecutive synced samples disagree with the level
    task automatic model_edge();
        logic [NK-1:0] s;
        s = ~m_d2; m_d2 = m_d1; m_d1 = KEY;
        m_press = 4'h0; m_rel = 4'h0;
        for (int i = 0; i < NK; i++) begin
            if (s[i] == m_prev[i]) begin
                if (m_run[i] < 100000) m_run[i] = m_run[i] + 1;
            end else begin
                m_run[i] = 1;
            end
            if (s[i] != m_down[i] && m_run[i] >= DB + 1) begin
                m_down[i] = s[i];
                m_rep[i]  = 0;
                if (s[i]) m_press[i] = 1'b1;
                else      m_rel[i]   = 1'b1;
            end else if (m_down[i] && s[i] && m_prev[i]) begin
`ifdef KEY_AUTOREPEAT_EN
                m_rep[i] = m_rep[i] + 1;
                if (m_rep[i] == RD || (m_rep[i] > RD && (m_rep[i] - RD) % RP == 0)) m_press[i] = 1'b1;
`endif
            end
            m_prev[i] = s[i];
        end
        if (m_press[0]) m_count = m_count + 8'd1;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (RESET) model_reset();
        else       model_edge();
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; KEY = 4'hF; model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got down=%b press=%b rel=%b cnt=%0d, expected all 0",
                         KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT);
            end
        end
        RESET = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_idle: got down=%b press=%b rel=%b cnt=%0d, expected all 0",
                         KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT);
            end
        end
    endtask

    task automatic test_press();
        KEY[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if (KEY_PRESS[0] !== (c == 7) || KEY_DOWN[0] !== (c >= 7)) begin
                n_fail++;
                $display("FAIL press_latency: tick %0d got press=%b down=%b, expected press=%b down=%b",
                         c, KEY_PRESS[0], KEY_DOWN[0], (c == 7), (c >= 7));
            end
            n_checks++;
            if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== {m_down, m_press, m_rel, m_count}) begin
                n_fail++;
                $display("FAIL press_model: got %b/%b/%b/%0d expected %b/%b/%b/%0d", KEY_DOWN, KEY_PRESS,
                         KEY_RELEASE, PRESS_COUNT, m_down, m_press, m_rel, m_count);
            end
        end
        n_checks++;
        if (PRESS_COUNT !== 8'd1) begin
            n_fail++;
            $display("FAIL press_count: got %0d expected 1", PRESS_COUNT);
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 40; c++) begin
            KEY[1] = (c < 30) ? (((c / 2) % 2) == 1) : 1'b1;
            tick();
            n_checks++;
            if (KEY_PRESS[1] !== 1'b0 || KEY_DOWN[1] !== 1'b0 || KEY_RELEASE[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_reject: tick %0d got press=%b down=%b rel=%b, expected 0",
                         c, KEY_PRESS[1], KEY_DOWN[1], KEY_RELEASE[1]);
            end
            n_checks++;
            if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== {m_down, m_press, m_rel, m_count}) begin
                n_fail++;
                $display("FAIL bounce_model: got %b/%b/%b/%0d expected %b/%b/%b/%0d", KEY_DOWN, KEY_PRESS,
                         KEY_RELEASE, PRESS_COUNT, m_down, m_press, m_rel, m_count);
            end
        end
        KEY[0] = 1'b1;
        for (int c = 0; c < 12; c++) tick();
    endtask

    task automatic test_simultaneous();
        KEY[3:2] = 2'b00;
        for (int c = 1; c <= 40; c++) begin
            if (c == 21) KEY[3:2] = 2'b11;
            tick();
            n_checks++;
            if (KEY_PRESS[3:2] !== ((c == 7) ? 2'b11 : 2'b00) ||
                KEY_RELEASE[3:2] !== ((c == 27) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL simultaneous: tick %0d got press=%b rel=%b", c, KEY_PRESS[3:2], KEY_RELEASE[3:2]);
            end
            n_checks++;
            if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== {m_down, m_press, m_rel, m_count}) begin
                n_fail++;
                $display("FAIL simul_model: got %b/%b/%b/%0d expected %b/%b/%b/%0d", KEY_DOWN, KEY_PRESS,
                         KEY_RELEASE, PRESS_COUNT, m_down, m_press, m_rel, m_count);
            end
        end
    endtask

    task automatic test_wrap();
        RESET = 1'b1; model_reset(); tick(); RESET = 1'b0;
        for (int p = 0; p < 256; p++) begin
            int lo, ph;
            lo = $urandom_range(6, 10);
            ph = ($urandom_range(0, 3) == 0) ? 16 : 14;
            for (int c = 0; c < lo + ph; c++) begin
                KEY[0] = (c < lo) ? 1'b0 : ((ph == 16 && c >= lo + 7 && c < lo + 9) ? 1'b0 : 1'b1);
                tick();
                n_checks++;
                if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== {m_down, m_press, m_rel, m_count}) begin
                    n_fail++;
                    $display("FAIL wrap_model: press %0d got %b/%b/%b/%0d expected %b/%b/%b/%0d", p, KEY_DOWN,
                             KEY_PRESS, KEY_RELEASE, PRESS_COUNT, m_down, m_press, m_rel, m_count);
                end
            end
        end
        n_checks++;
        if (PRESS_COUNT !== 8'd0) begin
            n_fail++;
            $display("FAIL count_wrap: got %0d expected 0", PRESS_COUNT);
        end
    endtask

    task automatic test_reset_held();
        KEY[0] = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        RESET = 1'b1; model_reset(); #1;
        n_checks++;
        if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_async: got down=%b cnt=%0d expected 0", KEY_DOWN, PRESS_COUNT);
        end
        tick(); tick();
        RESET = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_checks++;
            if (KEY_PRESS[0] !== (c == 7) || PRESS_COUNT !== ((c >= 7) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL reset_repress: tick %0d got press=%b cnt=%0d", c, KEY_PRESS[0], PRESS_COUNT);
            end
        end
        KEY[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_random();
        int dur [NK];
        for (int i = 0; i < NK; i++) dur[i] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                dur[i] = dur[i] - 1;
                if (dur[i] <= 0) begin
                    KEY[i] = ~KEY[i];
                    dur[i] = $urandom_range(1, 12);
                end
            end
            tick();
            n_checks++;
            if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== {m_down, m_press, m_rel, m_count}) begin
                n_fail++;
                $display("FAIL random_model: cyc %0d got %b/%b/%b/%0d expected %b/%b/%b/%0d", c, KEY_DOWN,
                         KEY_PRESS, KEY_RELEASE, PRESS_COUNT, m_down, m_press, m_rel, m_count);
            end
            n_checks++;
            if ((KEY_PRESS & KEY_RELEASE) !== 4'h0) begin
                n_fail++;
                $display("FAIL pulse_exclusive: got press=%b rel=%b", KEY_PRESS, KEY_RELEASE);
            end
        end
        KEY = 4'hF;
        for (int c = 0; c < 12; c++) tick();
    endtask

    task automatic test_autorepeat();
        int found, pulses;
        bit exp;
        found = 0; pulses = 0;
        KEY[0] = 1'b0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (KEY_PRESS[0] === 1'b1) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL repeat_first: got no press within 20 cycles, expected one");
        end
        for (int off = 1; off <= 30; off++) begin
            tick();
`ifdef KEY_AUTOREPEAT_EN
            exp = (off == RD) || (off > RD && ((off - RD) % RP) == 0);
`else
            exp = 1'b0;
`endif
            if (KEY_PRESS[0] === 1'b1) pulses++;
            n_checks++;
            if (KEY_PRESS[0] !== exp || KEY_DOWN[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL repeat_pulse: +%0d got press=%b down=%b expected press=%b down=1",
                         off, KEY_PRESS[0], KEY_DOWN[0], exp);
            end
            n_checks++;
            if ({KEY_DOWN, KEY_PRESS, KEY_RELEASE, PRESS_COUNT} !== {m_down, m_press, m_rel, m_count}) begin
                n_fail++;
                $display("FAIL repeat_model: got %b/%b/%b/%0d expected %b/%b/%b/%0d", KEY_DOWN, KEY_PRESS,
                         KEY_RELEASE, PRESS_COUNT, m_down, m_press, m_rel, m_count);
            end
        end
`ifndef KEY_AUTOREPEAT_EN
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL no_repeat: got %0d extra pulses expected 0", pulses);
        end
`endif
        KEY[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick();
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_simultaneous();
        test_wrap();
        test_reset_held();
        test_random();
        test_autorepeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
